renkon_unpool: RTL and testbench
================================

RENKON_UNPOOL -- requirements
Module: renkon_unpool

Interface
REQ-001 Parameter DWIDTH, default 16, pixel data width (signed).
REQ-002 Parameter LWIDTH, default 10, width of size/config fields.
REQ-003 Parameter MAXW, default 256, maximum pooled row length held in the row buffer.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 xrst  in  1  reset; asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; begins one feature map; ignored unless IDLE.
REQ-007 w_fea_size  in  LWIDTH  output (full-resolution) map side length, square map.
REQ-008 w_pool_size  in  LWIDTH  expansion factor per axis.
REQ-009 in_valid / in_ready  in / out  1 / 1  pooled-pixel handshake.
REQ-010 pixel_in  in  DWIDTH  signed pooled pixel, raster order.
REQ-011 out_valid / out_ready  out / in  1 / 1  expanded-pixel handshake.
REQ-012 pixel_out  out  DWIDTH  signed expanded pixel, raster order.
REQ-013 busy  out  1  high from the cycle after an accepted start until done.
REQ-014 done  out  1  one-cycle pulse after the last output beat.

Function
REQ-015 The block SHALL expand a pooled map into a full map, as the inverse of the 2x2-style pooling stage: each pooled pixel covers a P x P output window.
REQ-016 On accepted start, the block SHALL latch F=w_fea_size and P=w_pool_size (P=0 treated as 1); the pooled side N=floor(F/P); the output side is N*P; the remaining F-N*P rows/columns are not produced.
REQ-017 The states SHALL be IDLE, LOAD, EMIT, FIN; IDLE->LOAD on start with N>0; IDLE->FIN on start with N=0; FIN->IDLE after one cycle asserting done.
REQ-018 In LOAD, in_ready=1; each in_valid&in_ready beat writes the row buffer at column index c; after N beats go to EMIT.
REQ-019 In EMIT, the block SHALL emit N*P beats per output row, with pixel_out equal to rowbuf[ox/P]; it SHALL repeat the row P times; then go to LOAD for the next pooled row, or to FIN after pooled row N-1.
REQ-020 Transfers SHALL occur only when valid&ready are both high; pixel_out and out_valid SHALL hold stable while out_valid&!out_ready.
REQ-021 in_ready SHALL be 0 outside LOAD, and out_valid SHALL be 0 outside EMIT.
REQ-022 Latency: the first out_valid SHALL occur 2 cycles after the last LOAD beat of a row (1 cycle for the RAM read plus the output register).
REQ-023 Counters (column, sub-column, sub-row, row) SHALL wrap exactly at N-1/P-1; no beat is skipped or duplicated across out_ready stalls.
REQ-024 start asserted while busy SHALL be ignored, and the latched config SHALL remain unchanged.
REQ-025 N>MAXW is unsupported; the block SHALL clamp N to MAXW.

Reset
REQ-026 While xrst=1, the state SHALL be IDLE, all counters 0, and in_ready, out_valid, busy, done and pixel_out 0.
REQ-027 Reset asserted mid-map SHALL abort the map with no done pulse; row buffer contents are don't-care.

Configuration
REQ-028 RENKON_UNPOOL_ZERO_EN defined: zero-insertion mode; pixel_out=rowbuf value only at window position (0,0), and 0 at every other window position. Not defined: nearest-neighbour replication per REQ-019. The beat count and timing SHALL be identical in both modes.

Structure
REQ-029 The state encoding, and the DWIDTH/LWIDTH constants, SHALL live in the shared renkon package header alongside the existing renkon definitions.
REQ-030 Sub-module renkon_unpool_rowbuf: single-port-write, single-port-read synchronous RAM of MAXW x DWIDTH with 1-cycle read latency.

Verification
REQ-031 F=4, P=2, inputs 1,2,3,4 with out_ready=1 -> outputs 1,1,2,2 / 1,1,2,2 / 3,3,4,4 / 3,3,4,4, then done 1 cycle after beat 16.
REQ-032 F=5, P=2 -> N=2; exactly 16 output beats; in_ready drops after 4 input beats total.
REQ-033 Random out_ready (50%), F=6, P=3, inputs 10..13 -> sequence identical to the no-stall case, and pixel_out stable during stalls.
REQ-034 F=0 start -> busy 1 cycle, done pulse, zero output beats; P=0 with F=3 -> behaves as P=1 (9 beats echoing input).
REQ-035 xrst pulsed after output beat 5 of REQ-031 -> all outputs 0 immediately; a new start then yields the full correct 16-beat sequence.
REQ-036 With RENKON_UNPOOL_ZERO_EN, REQ-031 stimulus -> 1,0,2,0 / 0,0,0,0 / 3,0,4,0 / 0,0,0,0.

Source files
------------

// File: rtl/renkon_unpool_pkg.sv
// renkon_unpool_pkg -- shared definitions for the renkon unpooling block.
//   RENKON_DWIDTH : default signed pixel width
//   RENKON_LWIDTH : default width of size/config fields
//   unpool_state_t: controller states (idle, row load, row emit, finish)
package renkon_unpool_pkg;

   localparam int RENKON_DWIDTH = 16;
   localparam int RENKON_LWIDTH = 10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_EMIT,
      S_FIN
   } unpool_state_t;

endpackage

// File: rtl/renkon_unpool_rowbuf.sv
// renkon_unpool_rowbuf -- one pooled row of pixels.
// Synchronous RAM, MAXW x DWIDTH, one write port and one read port.
// The read data register updates only when rd_en is high, so it holds its
// value while the downstream output stage is stalled.
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request
//   rd_data          : read data, valid one cycle after rd_en
module renkon_unpool_rowbuf
   import renkon_unpool_pkg::*;
#(
   parameter int DWIDTH = RENKON_DWIDTH,
   parameter int MAXW   = 256,
   parameter int AW     = (MAXW > 1) ? $clog2(MAXW) : 1
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic signed [DWIDTH-1:0] wr_data,
   input  logic                     rd_en,
   input  logic [AW-1:0]            rd_addr,
   output logic signed [DWIDTH-1:0] rd_data
);

   logic signed [DWIDTH-1:0] mem [MAXW];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/renkon_unpool.sv
// renkon_unpool -- expands a pooled square map back to full resolution.
// Each pooled pixel covers a P x P output window. A pooled row is loaded into
// the row buffer, then replayed as P output rows of N*P pixels.
// Optional build macro RENKON_UNPOOL_ZERO_EN: zero-insertion mode (pooled
// value only at window position (0,0), zero elsewhere); same beat timing.
//   clk, xrst                 : clock, async active-high reset
//   start                     : begin one map (honoured only when idle)
//   w_fea_size, w_pool_size   : full map side F, expansion factor P (0 -> 1)
//   in_valid/in_ready/pixel_in     : pooled pixel stream, raster order
//   out_valid/out_ready/pixel_out  : expanded pixel stream, raster order
//   busy                      : map in progress
//   done                      : one-cycle pulse after the last output beat
module renkon_unpool
   import renkon_unpool_pkg::*;
#(
   parameter int DWIDTH = RENKON_DWIDTH,
   parameter int LWIDTH = RENKON_LWIDTH,
   parameter int MAXW   = 256
) (
   input  logic                     clk,
   input  logic                     xrst,
   input  logic                     start,
   input  logic [LWIDTH-1:0]        w_fea_size,
   input  logic [LWIDTH-1:0]        w_pool_size,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DWIDTH-1:0] pixel_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DWIDTH-1:0] pixel_out,
   output logic                     busy,
   output logic                     done
);

   localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;
   localparam logic [LWIDTH-1:0] ONE = LWIDTH'(1);

   unpool_state_t state, state_nx;

   logic [LWIDTH-1:0] p_eff, n_div, n_start;
   logic [LWIDTH-1:0] n_q, p_q;
   logic [LWIDTH-1:0] c_q, sc_q, sr_q, r_q;
   logic              issue_done_q;
   logic              s1_v, s1_last, out_last;
`ifdef RENKON_UNPOOL_ZERO_EN
   logic              s1_first;
`endif
   logic signed [DWIDTH-1:0] rd_data, emit_value;

   logic in_fire, out_fire, out_load, issue, last_fire;
   logic sc_wrap, c_wrap, sr_wrap, issue_last, row_last;

   // Config decode at start: P=0 means 1, N clamped to the buffer depth.
   always_comb begin
      p_eff   = (w_pool_size == '0) ? ONE : w_pool_size;
      n_div   = w_fea_size / p_eff;
      n_start = (n_div > LWIDTH'(MAXW)) ? LWIDTH'(MAXW) : n_div;
   end

   always_comb begin
      sc_wrap    = (sc_q == p_q - ONE);
      c_wrap     = (c_q == n_q - ONE);
      sr_wrap    = (sr_q == p_q - ONE);
      issue_last = sc_wrap && c_wrap && sr_wrap;
      row_last   = (r_q == n_q - ONE);
      in_fire    = in_valid && in_ready;
      out_fire   = out_valid && out_ready;
      last_fire  = out_fire && out_last;
      // Two-stage read pipeline: RAM read (s1) then output register.
      // A new read is issued only when s1 is empty or moving on, so the
      // RAM data register never gets overwritten under a stall.
      out_load   = s1_v && (!out_valid || out_ready);
      issue      = (state == S_EMIT) && !issue_done_q && (!s1_v || out_load);
   end

   // State register
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = (n_start == '0) ? S_FIN : S_LOAD;
         S_LOAD:  if (in_fire && c_wrap) state_nx = S_EMIT;
         S_EMIT:  if (last_fire) state_nx = row_last ? S_FIN : S_LOAD;
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready = (state == S_LOAD);
      busy     = (state != S_IDLE);
      done     = (state == S_FIN);
   end

   // Config latch and counters. Emit counters wrap back to zero on the last
   // issued beat of a row, so the next LOAD starts from column 0.
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         n_q          <= '0;
         p_q          <= '0;
         c_q          <= '0;
         sc_q         <= '0;
         sr_q         <= '0;
         r_q          <= '0;
         issue_done_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               n_q          <= n_start;
               p_q          <= p_eff;
               c_q          <= '0;
               sc_q         <= '0;
               sr_q         <= '0;
               r_q          <= '0;
               issue_done_q <= 1'b0;
            end
            S_LOAD: if (in_fire) begin
               c_q <= c_wrap ? '0 : c_q + ONE;
               if (c_wrap) issue_done_q <= 1'b0;
            end
            S_EMIT: begin
               if (issue) begin
                  if (sc_wrap) begin
                     sc_q <= '0;
                     if (c_wrap) begin
                        c_q  <= '0;
                        sr_q <= sr_wrap ? '0 : sr_q + ONE;
                     end else begin
                        c_q <= c_q + ONE;
                     end
                  end else begin
                     sc_q <= sc_q + ONE;
                  end
                  if (issue_last) issue_done_q <= 1'b1;
               end
               if (last_fire) r_q <= r_q + ONE;
            end
            default: ;
         endcase
      end
   end

`ifdef RENKON_UNPOOL_ZERO_EN
   always_comb emit_value = s1_first ? rd_data : '0;
`else
   always_comb emit_value = rd_data;
`endif

   // Read stage flags and output register
   always_ff @(posedge clk or posedge xrst) begin
      if (xrst) begin
         s1_v      <= 1'b0;
         s1_last   <= 1'b0;
`ifdef RENKON_UNPOOL_ZERO_EN
         s1_first  <= 1'b0;
`endif
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         pixel_out <= '0;
      end else begin
         if (issue) begin
            s1_v     <= 1'b1;
            s1_last  <= issue_last;
`ifdef RENKON_UNPOOL_ZERO_EN
            s1_first <= (sc_q == '0) && (sr_q == '0);
`endif
         end else if (out_load) begin
            s1_v <= 1'b0;
         end
         if (out_load) begin
            out_valid <= 1'b1;
            out_last  <= s1_last;
            pixel_out <= emit_value;
         end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pixel_out <= '0;
         end
      end
   end

   renkon_unpool_rowbuf #(
      .DWIDTH (DWIDTH),
      .MAXW   (MAXW),
      .AW     (AW)
   ) u_rowbuf (
      .clk     (clk),
      .wr_en   (in_fire),
      .wr_addr (c_q[AW-1:0]),
      .wr_data (pixel_in),
      .rd_en   (issue),
      .rd_addr (c_q[AW-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_renkon_unpool.sv
// tb_renkon_unpool -- self-checking bench for renkon_unpool.
// Expected output streams are built from the pooled input list with plain
// index arithmetic (output (oy,ox) <- pooled (oy/P, ox/P)).
module tb_renkon_unpool;

   localparam int DW   = 16;
   localparam int LW   = 10;
   localparam int MAXW = 8;

   logic                 clk = 1'b0;
   logic                 xrst = 1'b1;
   logic                 start = 1'b0;
   logic [LW-1:0]        w_fea_size = '0;
   logic [LW-1:0]        w_pool_size = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] pixel_in = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic signed [DW-1:0] pixel_out;
   logic                 busy;
   logic                 done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   renkon_unpool #(
      .DWIDTH (DW),
      .LWIDTH (LW),
      .MAXW   (MAXW)
   ) dut (
      .clk         (clk),
      .xrst        (xrst),
      .start       (start),
      .w_fea_size  (w_fea_size),
      .w_pool_size (w_pool_size),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .pixel_in    (pixel_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .pixel_out   (pixel_out),
      .busy        (busy),
      .done        (done)
   );

   // Runs one map. base >= 0 gives inputs base, base+1, ...; otherwise random.
   // abort_after > 0 pulses reset right after that many output beats.
   task automatic run_map(input string name, input int f, input int p,
                          input int in_stall, input int out_stall,
                          input int base, input int abort_after);
      int pe, n, side, in_idx, out_idx, done_cnt, busy_cnt, last_out, last_in;
      bit wait_first, prev_stall, ended;
      logic signed [DW-1:0] prev_pix;
      logic signed [DW-1:0] src[$];
      logic signed [DW-1:0] exp_q[$];

      pe = (p == 0) ? 1 : p;
      n  = f / pe;
      if (n > MAXW) n = MAXW;
      side = n * pe;
      for (int k = 0; k < n * n; k++)
         src.push_back((base >= 0) ? 16'(base + k) : 16'($urandom));
      for (int oy = 0; oy < side; oy++)
         for (int ox = 0; ox < side; ox++) begin
`ifdef RENKON_UNPOOL_ZERO_EN
            if ((oy % pe == 0) && (ox % pe == 0)) exp_q.push_back(src[(oy / pe) * n + ox / pe]);
            else exp_q.push_back('0);
`else
            exp_q.push_back(src[(oy / pe) * n + ox / pe]);
`endif
         end

      @(negedge clk);
      w_fea_size  = LW'(f);
      w_pool_size = LW'(p);
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;

      in_idx = 0; out_idx = 0; done_cnt = 0; busy_cnt = 0;
      last_out = -1; last_in = 0;
      wait_first = 0; prev_stall = 0; ended = 0; prev_pix = '0;

      // Iteration cyc observes the state left by clock edge cyc; a handshake
      // decided in iteration cyc completes on edge cyc+1.
      for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
         // A start while busy, with different sizes, must change nothing.
         if (n > 0 && cyc == 1) begin
            start       = 1'b1;
            w_fea_size  = LW'($urandom_range(1, 15));
            w_pool_size = LW'($urandom_range(1, 3));
         end else begin
            start = 1'b0;
         end
         in_valid = (in_idx < n * n) && ($urandom_range(99) >= in_stall);
         if (in_idx < n * n) pixel_in = src[in_idx];
         else pixel_in = '0;
         out_ready = ($urandom_range(99) >= out_stall);

         if (busy === 1'b1) busy_cnt++;
         if (cyc == 0) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy_after_start got %b want 1", name, busy);
            end
         end
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || pixel_out !== prev_pix) begin
               errors++;
               $display("FAIL %s stall_hold cyc %0d got v=%b d=%0d want v=1 d=%0d",
                        name, cyc, out_valid, pixel_out, prev_pix);
            end
         end
         checks++;
         if (out_valid === 1'b1 && in_ready === 1'b1) begin
            errors++;
            $display("FAIL %s ready_valid_exclusive cyc %0d got both 1 want not both", name, cyc);
         end
         if (in_idx == n * n) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s in_ready_after_last cyc %0d got %b want 0", name, cyc, in_ready);
            end
         end
         if (out_valid === 1'b1 && wait_first) begin
            checks++;
            wait_first = 0;
            if (cyc - (last_in + 1) != 2) begin
               errors++;
               $display("FAIL %s row_latency got %0d want 2", name, cyc - (last_in + 1));
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (out_idx >= exp_q.size()) begin
               errors++;
               $display("FAIL %s extra_beat idx %0d got %0d want none", name, out_idx, pixel_out);
            end else if (pixel_out !== exp_q[out_idx]) begin
               errors++;
               $display("FAIL %s beat %0d got %0d want %0d", name, out_idx, pixel_out, exp_q[out_idx]);
            end
            out_idx++;
            last_out = cyc;
         end
         if (in_valid && in_ready === 1'b1) begin
            in_idx++;
            if (in_idx % n == 0) begin
               last_in    = cyc;
               wait_first = 1;
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            checks++;
            if (cyc != last_out + 1) begin
               errors++;
               $display("FAIL %s done_timing got cyc %0d want %0d", name, cyc, last_out + 1);
            end
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_pix   = pixel_out;

         if (abort_after > 0 && out_idx == abort_after) begin
            @(posedge clk);
            #1 xrst = 1'b1;
            #1;
            checks++;
            if ({in_ready, out_valid, busy, done} !== 4'b0 || pixel_out !== '0) begin
               errors++;
               $display("FAIL %s reset_mid got rdy=%b v=%b busy=%b done=%b d=%0d want all 0",
                        name, in_ready, out_valid, busy, done, pixel_out);
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            start     = 1'b0;
            @(negedge clk);
            xrst = 1'b0;
            return;
         end

         if (cyc > 0 && busy !== 1'b1) ended = 1;
         else @(negedge clk);
      end

      in_valid  = 1'b0;
      out_ready = 1'b0;
      start     = 1'b0;
      checks++;
      if (!ended) begin
         errors++;
         $display("FAIL %s timeout got busy=%b want idle", name, busy);
      end
      checks++;
      if (out_idx != side * side) begin
         errors++;
         $display("FAIL %s out_count got %0d want %0d", name, out_idx, side * side);
      end
      checks++;
      if (in_idx != n * n) begin
         errors++;
         $display("FAIL %s in_count got %0d want %0d", name, in_idx, n * n);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL %s done_count got %0d want 1", name, done_cnt);
      end
      if (n == 0) begin
         checks++;
         if (busy_cnt != 1) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want 1", name, busy_cnt);
         end
      end
   endtask

   task automatic test_reset();
      xrst  = 1'b1;
      start = 1'b1;
      w_fea_size  = LW'(4);
      w_pool_size = LW'(2);
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, done} !== 4'b0 || pixel_out !== '0) begin
         errors++;
         $display("FAIL reset_state got rdy=%b v=%b busy=%b done=%b d=%0d want all 0",
                  in_ready, out_valid, busy, done, pixel_out);
      end
      start = 1'b0;
      @(negedge clk);
      xrst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b want 0", busy);
      end
   endtask

   task automatic test_basic();
      run_map("basic_f4_p2", 4, 2, 0, 0, 1, 0);
   endtask

   task automatic test_truncate();
      run_map("trunc_f5_p2", 5, 2, 20, 0, -1, 0);
   endtask

   task automatic test_stall();
      run_map("stall_f6_p3", 6, 3, 0, 50, 10, 0);
   endtask

   task automatic test_degenerate();
      run_map("zero_f0", 0, 2, 0, 0, -1, 0);
      run_map("p0_f3", 3, 0, 0, 0, -1, 0);
   endtask

   task automatic test_reset_mid();
      run_map("abort_f4_p2", 4, 2, 0, 0, 1, 5);
      run_map("after_abort", 4, 2, 0, 0, 1, 0);
   endtask

   task automatic test_clamp();
      run_map("clamp_f20_p1", 20, 1, 10, 10, -1, 0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 12; t++)
         run_map("random", int'($urandom_range(0, 20)), int'($urandom_range(0, 4)), 30, 30, -1, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_truncate();
      test_stall();
      test_degenerate();
      test_reset_mid();
      test_clamp();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
